fsm_run_ctrl: RTL and testbench
===============================

FSM_RUN_CTRL -- requirements
Module: fsm_run_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 8, meaning the width of the run-length and elapsed-count fields.
REQ-002 SHALL have parameter ACK_MODE, default 0, meaning 0 = DONE lasts one cycle and 1 = DONE holds until i_ack.
REQ-003 SHALL have port i_clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_reset_async_n  input  1  the reset, asynchronous and active-low.
REQ-005 SHALL have port i_isRun  input  1  the start request, sampled only in IDLE.
REQ-006 SHALL have port i_run_len  input  CNT_WIDTH  the number of RUN cycles, latched on the start edge.
REQ-007 SHALL have port i_abort  input  1  the cancel request, effective only in RUN.
REQ-008 SHALL have port i_ack  input  1  the DONE acknowledge, used only when ACK_MODE=1.
REQ-009 SHALL have port o_state  output  2  the current state encoding.
REQ-010 SHALL have port o_busy  output  1  high exactly when state is RUN.
REQ-011 SHALL have port o_done  output  1  high exactly when state is DONE.
REQ-012 SHALL have port o_aborted  output  1  a registered one-cycle pulse in the cycle after an abort is taken.
REQ-013 SHALL have port o_count  output  CNT_WIDTH  the number of RUN cycles completed.

Function
REQ-014 SHALL use these state encodings: IDLE=2'b00, RUN=2'b01, DONE=2'b10; the unused code 2'b11 SHALL go to IDLE on the next edge with all outputs at reset values.
REQ-015 SHALL, on an edge in IDLE with i_isRun=1, go to RUN, latch i_run_len into len_q and clear o_count to 0.
REQ-016 SHALL treat a latched len_q of 0 as 1, so RUN always lasts at least one cycle.
REQ-017 SHALL increment o_count by 1 on every RUN edge; RUN SHALL last exactly max(len_q,1) cycles, then go to DONE.
REQ-018 SHALL, at the maximum value (i_run_len = 2^CNT_WIDTH-1), complete without wrap: o_count ends at 2^CNT_WIDTH-1.
REQ-019 SHALL, on an edge in RUN with i_abort=1, go to IDLE without visiting DONE and pulse o_aborted for 1 cycle.
REQ-020 SHALL give abort priority when abort coincides with the final RUN cycle: go to IDLE, o_done never asserts.
REQ-021 SHALL, in DONE with ACK_MODE=0, return to IDLE after 1 cycle and ignore i_ack.
REQ-022 SHALL, in DONE with ACK_MODE=1, hold DONE until an edge with i_ack=1, then go to IDLE.
REQ-023 SHALL, in ACK_MODE=1, ignore i_ack outside DONE.
REQ-024 SHALL ignore i_isRun in RUN and DONE; at least one IDLE cycle separates runs.
REQ-025 SHALL ignore i_abort in IDLE and DONE.
REQ-026 SHALL hold o_count at its final value through DONE and IDLE until the next start.
REQ-027 SHALL derive o_busy and o_done combinationally from the state register only, with no input-to-output paths.
REQ-028 SHALL register o_aborted.

Reset
REQ-029 SHALL, while i_reset_async_n=0, force immediately: state=IDLE, len_q=0, o_count=0, o_aborted=0, o_busy=0, o_done=0, o_state=2'b00.
REQ-030 SHALL, on reset asserted mid-RUN or mid-DONE, abandon the operation with no o_done and no o_aborted pulse.
REQ-031 SHALL begin operation on the first rising edge after reset deassertion.

Structure
REQ-032 SHALL place the state encodings (STATE_IDLE, STATE_RUN, STATE_DONE) in the shared package fsm_pkg for reuse by other FSM blocks and benches.
REQ-033 SHALL place the run-length counter and its terminal-count compare in one sub-module, fsm_run_counter (load, enable, count, last).
REQ-034 SHALL keep separate blocks for state register, next-state logic and output logic, with defaults assigned before the case statement.

Verification
REQ-035 SHALL cover: CNT_WIDTH=8, ACK_MODE=0, i_run_len=5, i_isRun pulsed 1 cycle -> o_busy high 5 cycles, o_count 0..5, o_done high 1 cycle, then IDLE.
REQ-036 SHALL cover: i_run_len=0 and i_run_len=255 -> RUN lasts 1 and 255 cycles respectively; o_count ends at 1 and 255.
REQ-037 SHALL cover: i_run_len=10 with i_abort in RUN cycle 4, plus a second run with abort on the final RUN cycle -> IDLE next cycle, o_aborted 1-cycle pulse, o_done never asserts.
REQ-038 SHALL cover: ACK_MODE=1, i_run_len=3, i_ack delayed 7 cycles -> o_done high until the edge with i_ack=1; an early i_ack during RUN has no effect.
REQ-039 SHALL cover: i_reset_async_n pulled low between clock edges mid-RUN -> all outputs 0 immediately; the next start runs normally.
REQ-040 SHALL cover: i_isRun held high continuously with i_run_len=2 -> repeating pattern RUN,RUN,DONE,IDLE (period 4).

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared FSM state encodings.
// Used by the run controller and any bench that decodes its state.
package fsm_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'b00,
    STATE_RUN  = 2'b01,
    STATE_DONE = 2'b10,
    STATE_BAD  = 2'b11
  } state_e;

endpackage

// File: rtl/fsm_run_ctrl_if.sv
// Request/status bundle of the run controller.
// The master drives requests; the slave returns status.
interface fsm_run_ctrl_if #(
  parameter int CNT_WIDTH = 8
);

  logic                 isRun;
  logic [CNT_WIDTH-1:0] run_len;
  logic                 abort;
  logic                 ack;
  logic [1:0]           state;
  logic                 busy;
  logic                 done;
  logic                 aborted;
  logic [CNT_WIDTH-1:0] count;

  modport master (
    output isRun, run_len, abort, ack,
    input  state, busy, done, aborted, count
  );

  modport slave (
    input  isRun, run_len, abort, ack,
    output state, busy, done, aborted, count
  );

endinterface

// File: rtl/fsm_run_counter.sv
// Run-length latch, elapsed counter and terminal-count compare.
// A zero length is treated as one so a run always has a last cycle.
module fsm_run_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] len_in,
  output logic [W-1:0] count,
  output logic         last
);

  logic [W-1:0] len_q;
  logic [W-1:0] len_d;
  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W-1:0] len_m1;

  // length and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q   <= '0;
      count_q <= '0;
    end else begin
      len_q   <= len_d;
      count_q <= count_d;
    end
  end

  // load on start, count while enabled
  always_comb begin
    len_d   = len_q;
    count_d = count_q;
    if (clear) begin
      len_d   = '0;
      count_d = '0;
    end else if (load) begin
      len_d   = len_in;
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  // last cycle when count reaches max(len,1)-1
  always_comb begin
    len_m1 = (len_q == '0) ? '0 : len_q - 1'b1;
    last   = (count_q == len_m1);
  end

  assign count = count_q;

endmodule

// File: rtl/fsm_run_ctrl.sv
// Run controller: IDLE -> RUN for a latched length -> DONE -> IDLE.
// Abort in RUN returns to IDLE and pulses o_aborted next cycle.
module fsm_run_ctrl
  import fsm_pkg::*;
#(
  parameter int CNT_WIDTH = 8,
  parameter int ACK_MODE  = 0
) (
  input  logic                 i_clock,
  input  logic                 i_reset_async_n,
  input  logic                 i_isRun,
  input  logic [CNT_WIDTH-1:0] i_run_len,
  input  logic                 i_abort,
  input  logic                 i_ack,
  output logic [1:0]           o_state,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_aborted,
  output logic [CNT_WIDTH-1:0] o_count
);

  state_e state_q;
  state_e state_d;
  logic   aborted_q;
  logic   aborted_d;
  logic   cnt_clear;
  logic   cnt_load;
  logic   cnt_en;
  logic   cnt_last;

  fsm_run_counter #(
    .W(CNT_WIDTH)
  ) u_cnt (
    .clk    (i_clock),
    .rst_n  (i_reset_async_n),
    .clear  (cnt_clear),
    .load   (cnt_load),
    .enable (cnt_en),
    .len_in (i_run_len),
    .count  (o_count),
    .last   (cnt_last)
  );

  // state and abort-pulse registers
  always_ff @(posedge i_clock or negedge i_reset_async_n) begin
    if (!i_reset_async_n) begin
      state_q   <= STATE_IDLE;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      aborted_q <= aborted_d;
    end
  end

  // next state and counter control
  always_comb begin
    state_d   = state_q;
    aborted_d = 1'b0;
    cnt_clear = 1'b0;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    unique case (1'b1)
      (state_q == STATE_IDLE): begin
        if (i_isRun) begin
          state_d  = STATE_RUN;
          cnt_load = 1'b1;
        end
      end
      (state_q == STATE_RUN): begin
        cnt_en = 1'b1;
        if (i_abort) begin
          state_d   = STATE_IDLE;
          aborted_d = 1'b1;
        end else if (cnt_last) begin
          state_d = STATE_DONE;
        end
      end
      (state_q == STATE_DONE): begin
        if (ACK_MODE == 0 || i_ack) begin
          state_d = STATE_IDLE;
        end
      end
      default: begin
        state_d   = STATE_IDLE;
        cnt_clear = 1'b1;
      end
    endcase
  end

  // status decoded from the state register only
  always_comb begin
    o_state = state_q;
    o_busy  = (state_q == STATE_RUN);
    o_done  = (state_q == STATE_DONE);
  end

  assign o_aborted = aborted_q;

endmodule

// File: tb/tb_fsm_run_ctrl.sv
// Bench for fsm_run_ctrl: ACK_MODE=0 and ACK_MODE=1 side by side,
// checked every cycle against a run-level model plus literal checks.
module tb_fsm_run_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  fsm_run_ctrl_if #(.CNT_WIDTH(8)) b0 ();
  fsm_run_ctrl_if #(.CNT_WIDTH(8)) b1 ();

  assign b1.isRun   = b0.isRun;
  assign b1.run_len = b0.run_len;
  assign b1.abort   = b0.abort;
  assign b1.ack     = b0.ack;

  fsm_run_ctrl #(.CNT_WIDTH(8), .ACK_MODE(0)) d0 (
    .i_clock         (clk),
    .i_reset_async_n (rst_n),
    .i_isRun         (b0.isRun),
    .i_run_len       (b0.run_len),
    .i_abort         (b0.abort),
    .i_ack           (b0.ack),
    .o_state         (b0.state),
    .o_busy          (b0.busy),
    .o_done          (b0.done),
    .o_aborted       (b0.aborted),
    .o_count         (b0.count)
  );

  fsm_run_ctrl #(.CNT_WIDTH(8), .ACK_MODE(1)) d1 (
    .i_clock         (clk),
    .i_reset_async_n (rst_n),
    .i_isRun         (b1.isRun),
    .i_run_len       (b1.run_len),
    .i_abort         (b1.abort),
    .i_ack           (b1.ack),
    .o_state         (b1.state),
    .o_busy          (b1.busy),
    .o_done          (b1.done),
    .o_aborted       (b1.aborted),
    .o_count         (b1.count)
  );

  int checks = 0;
  int errors = 0;
  int busy0_n = 0;
  int done0_n = 0;
  int ab0_n = 0;
  int done1_n = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // run-level model: cycles left in the run, a done flag, elapsed count
  typedef struct packed {
    int run_left;
    bit done;
    int cnt;
    bit ab;
  } model_t;

  model_t m0 = '0;
  model_t m1 = '0;

  function automatic model_t step(input model_t m, input bit ackmode,
                                  input bit isrun, input int len,
                                  input bit abort, input bit ack);
    model_t n;
    n = m;
    n.ab = 1'b0;
    if (m.run_left > 0) begin
      n.cnt = m.cnt + 1;
      if (abort) begin
        n.run_left = 0;
        n.ab = 1'b1;
      end else begin
        n.run_left = m.run_left - 1;
        if (n.run_left == 0) n.done = 1'b1;
      end
    end else if (m.done) begin
      if (!ackmode || ack) n.done = 1'b0;
    end else if (isrun) begin
      n.run_left = (len == 0) ? 1 : len;
      n.cnt = 0;
    end
    return n;
  endfunction

  function automatic int exp_state(input model_t m);
    if (m.run_left > 0) return 1;
    if (m.done) return 2;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      m0 <= step(m0, 1'b0, b0.isRun, int'(b0.run_len), b0.abort, b0.ack);
      m1 <= step(m1, 1'b1, b0.isRun, int'(b0.run_len), b0.abort, b0.ack);
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    chk("d0_state", int'(b0.state), exp_state(m0));
    chk("d0_busy", int'(b0.busy), int'(exp_state(m0) == 1));
    chk("d0_done", int'(b0.done), int'(exp_state(m0) == 2));
    chk("d0_aborted", int'(b0.aborted), int'(m0.ab));
    chk("d0_count", int'(b0.count), m0.cnt);
    chk("d1_state", int'(b1.state), exp_state(m1));
    chk("d1_busy", int'(b1.busy), int'(exp_state(m1) == 1));
    chk("d1_done", int'(b1.done), int'(exp_state(m1) == 2));
    chk("d1_aborted", int'(b1.aborted), int'(m1.ab));
    chk("d1_count", int'(b1.count), m1.cnt);
    if (b0.busy) busy0_n++;
    if (b0.done) done0_n++;
    if (b0.aborted) ab0_n++;
    if (b1.done) done1_n++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clr();
    busy0_n = 0;
    done0_n = 0;
    ab0_n = 0;
    done1_n = 0;
  endtask

  task automatic start(input int len);
    tick(1);
    b0.isRun = 1'b1;
    b0.run_len = 8'(len);
    tick(1);
    b0.isRun = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_d0_out"}, int'({b0.state, b0.busy, b0.done, b0.aborted}), 0);
    chk({tag, "_d0_cnt"}, int'(b0.count), 0);
    chk({tag, "_d1_out"}, int'({b1.state, b1.busy, b1.done, b1.aborted}), 0);
    chk({tag, "_d1_cnt"}, int'(b1.count), 0);
  endtask

  logic [1:0] pat [4] = '{2'd1, 2'd1, 2'd2, 2'd0};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    b0.isRun = 1'b0;
    b0.run_len = 8'd0;
    b0.abort = 1'b0;
    b0.ack = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_zero("reset");
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // length 5
    clr();
    start(5);
    tick(10);
    chk("len5_busy_cycles", busy0_n, 5);
    chk("len5_done_cycles", done0_n, 1);
    chk("len5_count", int'(b0.count), 5);

    // length 0 runs one cycle
    clr();
    start(0);
    tick(5);
    chk("len0_busy_cycles", busy0_n, 1);
    chk("len0_count", int'(b0.count), 1);

    // length 255 completes without wrap
    clr();
    start(255);
    tick(260);
    chk("len255_busy_cycles", busy0_n, 255);
    chk("len255_count", int'(b0.count), 255);
    chk("len255_done_cycles", done0_n, 1);

    // abort in RUN cycle 4 of 10
    clr();
    start(10);
    tick(3);
    b0.abort = 1'b1;
    tick(1);
    b0.abort = 1'b0;
    chk("abort4_state", int'(b0.state), 0);
    chk("abort4_pulse", int'(b0.aborted), 1);
    tick(1);
    chk("abort4_pulse_end", int'(b0.aborted), 0);
    tick(3);
    chk("abort4_no_done", done0_n + done1_n, 0);
    chk("abort4_pulses", ab0_n, 1);

    // abort on the final RUN cycle
    clr();
    start(3);
    tick(2);
    b0.abort = 1'b1;
    tick(1);
    b0.abort = 1'b0;
    chk("abortlast_state", int'(b0.state), 0);
    chk("abortlast_pulse", int'(b0.aborted), 1);
    tick(3);
    chk("abortlast_no_done", done0_n + done1_n, 0);

    // ack mode: early ack in RUN, ack withheld 7 cycles in DONE
    clr();
    start(3);
    tick(2);
    b0.ack = 1'b0;
    tick(7);
    b0.ack = 1'b1;
    chk("ack_hold_done", int'(b1.done), 1);
    tick(1);
    chk("ack_release", int'(b1.state), 0);
    tick(2);
    chk("ack_done_cycles", done1_n, 7);
    chk("ack0_done_cycles", done0_n, 1);

    // async reset mid-RUN
    clr();
    start(20);
    tick(3);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrun_reset");
    tick(1);
    rst_n = 1'b1;
    tick(3);
    chk("reset_no_done_abort", done0_n + ab0_n + done1_n, 0);
    clr();
    start(2);
    tick(6);
    chk("after_reset_count", int'(b0.count), 2);
    chk("after_reset_busy", busy0_n, 2);
    chk("after_reset_done", done0_n, 1);

    // continuous start request, length 2
    b0.isRun = 1'b1;
    b0.run_len = 8'd2;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      chk("repeat_pattern", int'(b0.state), int'(pat[i % 4]));
    end
    b0.isRun = 1'b0;
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
